if_fetch_queue: RTL

- Instruction-fetch stage directly downstream of the 32-bit PC register.
- Each cycle it takes the current PC, issues a handshaked request to instruction memory and pulses pc_en so the PC register loads PC+4 (adder is external).
- Returned {pc, instr} pairs are buffered in a small FIFO and handed to decode with valid/ready.
- Branch/jump redirects flush the queue and discard any in-flight response.

---
 rtl/if_fetch_queue.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_fetch_queue                                                |
// | Purpose  : Instruction-fetch stage behind the PC register. Issues one    |
// |            handshaked fetch at a time, pulses pc_en on acceptance,       |
// |            buffers returned {pc, instr} pairs in a DEPTH-entry FIFO and  |
// |            hands them to decode with valid/ready. A flush empties the    |
// |            FIFO and discards the response of an outstanding fetch.       |
// | Options  : IF_ALIGN_CHECK_EN - misaligned PCs bypass memory and enqueue  |
// |            a fault entry (id_misalign = 1, id_instr = 0).                |
// | Ports    : clk/reset        - clock, async active-high reset            |
// |            pc/pc_en         - current PC in, load-next-PC pulse out      |
// |            flush            - redirect, kills queue and in-flight fetch  |
// |            imem_req_*       - fetch request handshake, imem_addr = pc    |
// |            imem_resp_*      - fetch response (valid + 32-bit data)       |
// |            id_*             - head entry to decode (valid/ready)         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module if_fetch_queue #(
   parameter int DEPTH = 2,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] pc,
   output logic          pc_en,
   input  logic          flush,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_resp_valid,
   input  logic [31:0]   imem_resp_data,
   output logic          id_valid,
   input  logic          id_ready,
   output logic [AW-1:0] id_pc,
   output logic [31:0]   id_instr,
   output logic          id_misalign
);

   localparam int            c_pw    = $clog2(DEPTH);
   localparam int            c_cw    = $clog2(DEPTH) + 1;
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t          r_state;
   logic [c_pw-1:0] r_wr_ptr;
   logic [c_pw-1:0] r_rd_ptr;
   logic [c_cw-1:0] r_count;
   logic [AW-1:0]   r_saved_pc;
   logic [AW-1:0]   r_mem_pc    [DEPTH];
   logic [31:0]     r_mem_instr [DEPTH];

   logic            w_space;
   logic            w_idle_ok;
   logic            w_misaligned;
   logic            w_req;
   logic            w_accept;
   logic            w_mis_push;
   logic            w_resp_push;
   logic            w_push;
   logic            w_pop;
   logic [AW-1:0]   w_push_pc;
   logic [31:0]     w_push_instr;

   assign w_space   = (r_count < c_depth);
   assign w_idle_ok = (r_state == ST_IDLE) && !flush && w_space;

`ifdef IF_ALIGN_CHECK_EN
   assign w_misaligned = (pc[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   assign w_req       = w_idle_ok && !w_misaligned;
   assign w_accept    = w_req && imem_req_ready;
   // A misaligned PC is turned into a fault entry without touching memory.
   assign w_mis_push  = w_idle_ok && w_misaligned;
   // Only one fetch is ever outstanding, so a slot is free when it returns.
   assign w_resp_push = (r_state == ST_WAIT) && imem_resp_valid && !flush;
   assign w_push      = w_resp_push || w_mis_push;
   assign w_pop       = (r_count != '0) && id_ready && !flush;

   assign w_push_pc    = w_mis_push ? pc : r_saved_pc;
   assign w_push_instr = w_mis_push ? 32'h0000_0000 : imem_resp_data;

   // Outputs forced low while reset is held so the stage is quiet in reset.
   assign imem_req_valid = w_req && !reset;
   assign pc_en          = (w_accept || w_mis_push) && !reset;
   assign imem_addr      = pc;
   assign id_valid       = (r_count != '0);
   assign id_pc          = r_mem_pc[r_rd_ptr];
   assign id_instr       = r_mem_instr[r_rd_ptr];

   // Fetch control: WAIT keeps the response, DROP discards it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_saved_pc <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state    <= ST_WAIT;
                  r_saved_pc <= pc;
               end
            end
            ST_WAIT: begin
               if (imem_resp_valid) r_state <= ST_IDLE;
               else if (flush)      r_state <= ST_DROP;
            end
            ST_DROP: begin
               if (imem_resp_valid) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_pc[i]    <= '0;
            r_mem_instr[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= w_push_pc;
            r_mem_instr[r_wr_ptr] <= w_push_instr;
            r_wr_ptr              <= r_wr_ptr + c_pw'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + c_pw'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef IF_ALIGN_CHECK_EN
   logic r_mem_mis [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem_mis[i] <= 1'b0;
      end else if (w_push && !flush) begin
         r_mem_mis[r_wr_ptr] <= w_mis_push;
      end
   end

   assign id_misalign = r_mem_mis[r_rd_ptr];
`else
   assign id_misalign = 1'b0;
`endif

endmodule
`default_nettype wire
